// File: rtl/lc3_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : lc3_fetch_queue
// Brief   : LC-3 fetch stage with a DEPTH-entry in-order prefetch queue and
//           taken-branch redirect/flush. Optional macro FETCH_QUEUE_BYPASS_EN
//           forwards a response straight to decode when the queue is empty.
// Revision: 1.0 - initial release
// ============================================================================
module lc3_fetch_queue #(
  parameter int          ADDR_W   = 16,
  parameter int          DATA_W   = 16,
  parameter int          DEPTH    = 4,
  parameter int unsigned RESET_PC = 32'h3000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable_fetch,
  input  logic                       enable_updatePC,
  input  logic [ADDR_W-1:0]          taddr,
  input  logic                       br_taken,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic                       imem_rvalid,
  input  logic [DATA_W-1:0]          imem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_instr,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [ADDR_W-1:0]          out_npc,
  output logic [$clog2(DEPTH):0]     q_count
);

  localparam int                c_ptr_w    = $clog2(DEPTH);
  localparam int                c_cnt_w    = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);
  localparam logic [ADDR_W-1:0]  c_reset_pc = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0]  r_fpc;
  logic [ADDR_W-1:0]  r_pend_pc;
  logic               r_pending;
  logic               r_drop;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic [DATA_W-1:0]  r_q_instr [DEPTH];
  logic [ADDR_W-1:0]  r_q_pc    [DEPTH];

  logic               w_redirect;
  logic               w_empty;
  logic               w_resp;
  logic               w_issue;
  logic               w_bypass;
  logic               w_push;
  logic               w_pop;
  logic               w_valid;
  logic [DATA_W-1:0]  w_instr;
  logic [ADDR_W-1:0]  w_pc;

  always_comb begin
    w_redirect = enable_updatePC && br_taken;
    w_empty    = (r_count == '0);
    w_resp     = imem_rvalid && r_pending;
    // Reset gating keeps the read strobe low while reset is held.
    w_issue    = !reset && enable_fetch && !w_redirect && !r_pending && (r_count < c_depth);
`ifdef FETCH_QUEUE_BYPASS_EN
    w_bypass   = w_empty && w_resp && !r_drop && !w_redirect;
`else
    w_bypass   = 1'b0;
`endif
    w_push     = w_resp && !r_drop && !w_redirect && !(w_bypass && out_ready);
    w_pop      = !w_empty && out_ready && !w_redirect;
    w_valid    = !w_empty || w_bypass;
    w_instr    = '0;
    w_pc       = '0;
    if (!w_empty) begin
      w_instr = r_q_instr[r_rd_ptr];
      w_pc    = r_q_pc[r_rd_ptr];
    end else if (w_bypass) begin
      w_instr = imem_rdata;
      w_pc    = r_pend_pc;
    end
  end

  assign imem_req  = w_issue;
  assign imem_addr = w_issue ? r_fpc : '0;
  assign out_valid = w_valid;
  assign out_instr = w_instr;
  assign out_pc    = w_pc;
  assign out_npc   = w_valid ? (w_pc + ADDR_W'(1)) : '0;
  assign q_count   = r_count;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_q_instr[r_wr_ptr] <= imem_rdata;
      r_q_pc[r_wr_ptr]    <= r_pend_pc;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fpc     <= c_reset_pc;
      r_pend_pc <= '0;
      r_pending <= 1'b0;
      r_drop    <= 1'b0;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
    end else if (w_redirect) begin
      r_fpc    <= taddr;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      // A response landing in the redirect cycle retires the read; only a
      // read still in flight afterwards needs to be marked stale.
      r_pending <= r_pending && !imem_rvalid;
      r_drop    <= r_pending && !imem_rvalid;
    end else begin
      if (w_issue) begin
        r_fpc     <= r_fpc + ADDR_W'(1);
        r_pend_pc <= r_fpc;
        r_pending <= 1'b1;
      end
      if (w_resp) begin
        r_pending <= 1'b0;
        r_drop    <= 1'b0;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lc3_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_lc3_fetch_queue
// Brief   : Self-checking bench for lc3_fetch_queue against a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lc3_fetch_queue;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable_fetch = 1'b0;
  logic        enable_updatePC = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] taddr = 16'h0;
  logic        out_ready = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = 16'h0;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic [15:0] out_npc;
  logic [2:0]  q_count;
  logic        spur_en = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  lc3_fetch_queue #(.ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH), .RESET_PC(32'h3000)) dut (
    .clock(clock), .reset(reset), .enable_fetch(enable_fetch),
    .enable_updatePC(enable_updatePC), .taddr(taddr), .br_taken(br_taken),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_npc(out_npc), .q_count(q_count)
  );

  // Instruction memory: mem[a] = a ^ A5A5, answered one cycle after the strobe.
  always @(posedge clock) begin
    imem_rvalid <= imem_req || (spur_en && ($urandom_range(0, 3) == 0));
    imem_rdata  <= imem_req ? (imem_addr ^ 16'hA5A5) : 16'($urandom);
  end

  // Reference model: the prefetch queue is an SV queue of (instr, pc) pairs.
  typedef struct packed { logic [15:0] instr; logic [15:0] pc; } ent_t;
  ent_t        mq[$];
  logic [15:0] m_fpc, m_ppc;
  bit          m_pending, m_drop;
  bit          e_redir, e_issue, e_byp, e_valid;
  logic [15:0] e_instr, e_pc;
  logic [68:0] e_all;
  logic [68:0] obs;
  assign obs = {imem_req, imem_addr, out_valid, out_instr, out_pc, out_npc, q_count};

  task automatic model_reset();
    m_fpc = 16'h3000; m_ppc = 16'h0; m_pending = 0; m_drop = 0;
    mq.delete();
  endtask

  task automatic model_eval();
    e_redir = enable_updatePC && br_taken;
    e_issue = enable_fetch && !e_redir && !m_pending && (mq.size() < DEPTH);
    e_byp   = 0;
`ifdef FETCH_QUEUE_BYPASS_EN
    e_byp   = (mq.size() == 0) && imem_rvalid && m_pending && !m_drop && !e_redir;
`endif
    e_valid = 0; e_instr = 16'h0; e_pc = 16'h0;
    if (mq.size() > 0) begin
      e_valid = 1; e_instr = mq[0].instr; e_pc = mq[0].pc;
    end else if (e_byp) begin
      e_valid = 1; e_instr = imem_rdata; e_pc = m_ppc;
    end
    e_all = {e_issue, (e_issue ? m_fpc : 16'h0), e_valid, e_instr, e_pc,
             (e_valid ? e_pc + 16'd1 : 16'h0), 3'(mq.size())};
  endtask

  task automatic model_tick();
    if (e_redir) begin
      mq.delete();
      m_fpc     = taddr;
      m_drop    = m_pending && !imem_rvalid;
      m_pending = m_drop;
    end else begin
      if (e_valid && out_ready && mq.size() > 0) void'(mq.pop_front());
      if (imem_rvalid && m_pending) begin
        if (!m_drop && !(e_byp && out_ready)) mq.push_back({imem_rdata, m_ppc});
        m_pending = 0;
        m_drop    = 0;
      end
      if (e_issue) begin
        m_ppc = m_fpc; m_fpc = m_fpc + 16'd1; m_pending = 1;
      end
    end
  endtask

  task automatic advance();
    model_tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1; enable_fetch = 0; enable_updatePC = 0; br_taken = 0; out_ready = 0; spur_en = 0;
    repeat (2) @(negedge clock);
    reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1; enable_fetch = 1; out_ready = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      if (obs !== 69'h0) begin
        failures++; $display("FAIL reset_outputs got=%h exp=%h", obs, 69'h0);
      end
      checks++;
      @(negedge clock);
    end
    reset = 0;
    model_reset();
    #1;
    if ({imem_req, imem_addr} !== {1'b1, 16'h3000}) begin
      failures++; $display("FAIL reset_first_fetch got=%b/%h exp=1/3000", imem_req, imem_addr);
    end
    checks++;
    advance();
  endtask

  task automatic test_stream();
    logic [15:0] exp_pc;
    int n_out;
    do_reset();
    enable_fetch = 1; out_ready = 1; exp_pc = 16'h3000; n_out = 0;
    for (int i = 0; i < 24; i++) begin
      #1; model_eval();
      if (obs !== e_all) begin
        failures++; $display("FAIL stream_model cyc=%0d got=%h exp=%h", i, obs, e_all);
      end
      checks++;
      if (out_valid && out_ready) begin
        if ({out_instr, out_pc, out_npc} !== {exp_pc ^ 16'hA5A5, exp_pc, exp_pc + 16'd1}) begin
          failures++;
          $display("FAIL stream_order got=%h/%h/%h exp=%h/%h/%h", out_instr, out_pc, out_npc,
                   exp_pc ^ 16'hA5A5, exp_pc, exp_pc + 16'd1);
        end
        checks++;
        exp_pc++; n_out++;
      end
      advance();
    end
    if (n_out < 11) begin
      failures++; $display("FAIL stream_rate got=%0d exp>=11", n_out);
    end
    checks++;
  endtask

  task automatic test_backpressure();
    int nreq, npop;
    bit got;
    logic [15:0] first_addr, exp_pc;
    do_reset();
    enable_fetch = 1; out_ready = 0; nreq = 0;
    for (int i = 0; i < 16; i++) begin
      #1; model_eval();
      if (obs !== e_all) begin
        failures++; $display("FAIL bp_fill_model cyc=%0d got=%h exp=%h", i, obs, e_all);
      end
      checks++;
      if (imem_req) nreq++;
      advance();
    end
    #1;
    if ({nreq, q_count, imem_req} !== {32'd4, 3'd4, 1'b0}) begin
      failures++; $display("FAIL bp_full got=reqs %0d cnt %0d req %b exp=reqs 4 cnt 4 req 0",
                           nreq, q_count, imem_req);
    end
    checks++;
    out_ready = 1; got = 0; first_addr = 16'h0; exp_pc = 16'h3000; npop = 0;
    for (int i = 0; i < 16; i++) begin
      #1; model_eval();
      if (obs !== e_all) begin
        failures++; $display("FAIL bp_drain_model cyc=%0d got=%h exp=%h", i, obs, e_all);
      end
      checks++;
      if (imem_req && !got) begin got = 1; first_addr = imem_addr; end
      if (out_valid && npop < 4) begin
        if (out_pc !== exp_pc) begin
          failures++; $display("FAIL bp_drain_pc got=%h exp=%h", out_pc, exp_pc);
        end
        checks++;
        exp_pc++; npop++;
      end
      advance();
    end
    if ({got, first_addr} !== {1'b1, 16'h3004}) begin
      failures++; $display("FAIL bp_resume got=%b/%h exp=1/3004", got, first_addr);
    end
    checks++;
  endtask

  task automatic test_redirect();
    bit found, seen;
    logic [15:0] last_addr;
    do_reset();
    enable_fetch = 1; out_ready = 0; found = 0; last_addr = 16'h0;
    for (int i = 0; i < 20 && !found; i++) begin
      #1; model_eval();
      if (obs !== e_all) begin
        failures++; $display("FAIL redir_pre_model cyc=%0d got=%h exp=%h", i, obs, e_all);
      end
      checks++;
      if (q_count == 3'd2 && imem_rvalid) found = 1;
      else begin
        if (imem_req) last_addr = imem_addr;
        advance();
      end
    end
    if ({found, last_addr} !== {1'b1, 16'h3002}) begin
      failures++; $display("FAIL redir_setup got=%b/%h exp=1/3002", found, last_addr);
    end
    checks++;
    enable_updatePC = 1; br_taken = 1; taddr = 16'h4000;
    #1; model_eval();
    if (obs !== e_all) begin
      failures++; $display("FAIL redir_cycle_model got=%h exp=%h", obs, e_all);
    end
    checks++;
    advance();
    enable_updatePC = 0; br_taken = 0; out_ready = 1;
    #1; model_eval();
    if ({q_count, imem_req, imem_addr} !== {3'd0, 1'b1, 16'h4000}) begin
      failures++; $display("FAIL redir_target got=%0d/%b/%h exp=0/1/4000", q_count, imem_req, imem_addr);
    end
    checks++;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin #1; model_eval(); end
      if (obs !== e_all) begin
        failures++; $display("FAIL redir_post_model cyc=%0d got=%h exp=%h", i, obs, e_all);
      end
      checks++;
      if (out_valid && !seen) begin
        seen = 1;
        if ({out_pc, out_instr} !== {16'h4000, 16'h4000 ^ 16'hA5A5}) begin
          failures++; $display("FAIL redir_first_out got=%h/%h exp=4000/%h", out_pc, out_instr,
                               16'h4000 ^ 16'hA5A5);
        end
        checks++;
      end
      advance();
    end
  endtask

  task automatic test_wrap();
    logic [15:0] pcs[2], npcs[2];
    int n;
    do_reset();
    enable_fetch = 1; out_ready = 1; enable_updatePC = 1; br_taken = 1; taddr = 16'hFFFF;
    #1; model_eval();
    advance();
    enable_updatePC = 0; br_taken = 0; n = 0;
    pcs[0] = 16'h1; pcs[1] = 16'h1; npcs[0] = 16'h1; npcs[1] = 16'h1;
    for (int i = 0; i < 12; i++) begin
      #1; model_eval();
      if (obs !== e_all) begin
        failures++; $display("FAIL wrap_model cyc=%0d got=%h exp=%h", i, obs, e_all);
      end
      checks++;
      if (out_valid && n < 2) begin pcs[n] = out_pc; npcs[n] = out_npc; n++; end
      advance();
    end
    if ({pcs[0], npcs[0], pcs[1], npcs[1]} !== {16'hFFFF, 16'h0000, 16'h0000, 16'h0001}) begin
      failures++; $display("FAIL wrap_pcs got=%h/%h %h/%h exp=ffff/0000 0000/0001",
                           pcs[0], npcs[0], pcs[1], npcs[1]);
    end
    checks++;
  endtask

  task automatic test_async_reset();
    bit found;
    do_reset();
    enable_fetch = 1; out_ready = 0; found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      #1; model_eval();
      if (obs !== e_all) begin
        failures++; $display("FAIL areset_fill_model cyc=%0d got=%h exp=%h", i, obs, e_all);
      end
      checks++;
      if (q_count == 3'd3 && imem_req) found = 1;
      advance();
    end
    if (!found) begin
      failures++; $display("FAIL areset_setup got=timeout exp=cnt 3 with req");
    end
    checks++;
    #1 reset = 1;
    #1;
    if (obs !== 69'h0) begin
      failures++; $display("FAIL areset_async got=%h exp=%h", obs, 69'h0);
    end
    checks++;
    #1 reset = 0;
    model_reset();
    #1; model_eval();
    if ({imem_req, imem_addr} !== {1'b1, 16'h3000}) begin
      failures++; $display("FAIL areset_restart got=%b/%h exp=1/3000", imem_req, imem_addr);
    end
    checks++;
    advance();
    #1; model_eval();
    if (q_count !== 3'd0) begin
      failures++; $display("FAIL areset_drop got=%0d exp=0", q_count);
    end
    checks++;
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin #1; model_eval(); end
      if (obs !== e_all) begin
        failures++; $display("FAIL areset_post_model cyc=%0d got=%h exp=%h", i, obs, e_all);
      end
      checks++;
      advance();
    end
  endtask

`ifdef FETCH_QUEUE_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    enable_fetch = 1; out_ready = 1;
    #1;
    advance();
    #1;
    if ({imem_rvalid, out_valid, out_instr, q_count} !== {1'b1, 1'b1, 16'h3000 ^ 16'hA5A5, 3'd0}) begin
      failures++; $display("FAIL bypass_same_cycle got=%b/%b/%h/%0d exp=1/1/%h/0",
                           imem_rvalid, out_valid, out_instr, q_count, 16'h3000 ^ 16'hA5A5);
    end
    checks++;
    @(posedge clock); @(negedge clock);
    #1;
    if (q_count !== 3'd0) begin
      failures++; $display("FAIL bypass_count got=%0d exp=0", q_count);
    end
    checks++;
  endtask
`endif

  task automatic test_random();
    do_reset();
    spur_en = 1;
    for (int i = 0; i < 600; i++) begin
      enable_fetch    = ($urandom_range(0, 3) != 0);
      out_ready       = ($urandom_range(0, 4) < 3);
      enable_updatePC = ($urandom_range(0, 1) == 1);
      br_taken        = ($urandom_range(0, 7) == 0);
      taddr           = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 3))
                                                    : 16'($urandom);
      #1; model_eval();
      if (obs !== e_all) begin
        failures++; $display("FAIL random_model cyc=%0d got=%h exp=%h", i, obs, e_all);
      end
      checks++;
      advance();
    end
    spur_en = 0; enable_updatePC = 0; br_taken = 0;
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_async_reset();
`ifdef FETCH_QUEUE_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
